// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types, constants and fixed-point helpers for the
// serial perceptron neuron.
//   neuron_state_t : FSM states {IDLE, MAC, ACT, DONE}
//   ACT_STEP/RELU  : activation mode selector values
//   fx_one         : fixed-point 1.0 (1 << q_n), returned 64 bits wide
//   sat_hi/sat_lo  : signed W-bit clamp limits, returned 128 bits wide
package neuron_pkg;

   typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} neuron_state_t;

   localparam int ACT_STEP = 0;
   localparam int ACT_RELU = 1;

   function automatic logic [63:0] fx_one(input int q_n);
      return 64'd1 << q_n;
   endfunction

   function automatic logic signed [127:0] sat_hi(input int w);
      return (128'sd1 <<< (w - 1)) - 128'sd1;
   endfunction

   function automatic logic signed [127:0] sat_lo(input int w);
      return -(128'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/neuron_mac_datapath.sv
// neuron_mac_datapath: operand select, shared signed multiplier with Q_N
// shift, wide accumulator and output saturator.
//   clk, rst      : clock, asynchronous active-high reset
//   clear, en     : accumulator clear (priority) and add-enable
//   idx           : term index; N_INPUTS selects the bias term
//   x_flat/w_flat : registered packed operands, element i at [i*W +: W]
//   wb            : registered bias weight
//   sat_sum       : accumulator clamped to W signed bits
module neuron_mac_datapath
   import neuron_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int W        = 32,
   parameter int Q_N      = 16,
   parameter logic [W-1:0] BIAS = W'(fx_one(Q_N)),
   parameter int IDX_W    = $clog2(N_INPUTS + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    en,
   input  logic [IDX_W-1:0]        idx,
   input  logic [N_INPUTS*W-1:0]   x_flat,
   input  logic [N_INPUTS*W-1:0]   w_flat,
   input  logic [W-1:0]            wb,
   output logic [W-1:0]            sat_sum
);

   // Guard bits cover the worst-case sum of N_INPUTS+1 full-width terms.
   localparam int ACC_W = 2*W + $clog2(N_INPUTS + 1);

   localparam logic signed [127:0]     SAT_HI_WIDE = sat_hi(W);
   localparam logic signed [127:0]     SAT_LO_WIDE = sat_lo(W);
   localparam logic signed [ACC_W-1:0] SAT_HI      = SAT_HI_WIDE[ACC_W-1:0];
   localparam logic signed [ACC_W-1:0] SAT_LO      = SAT_LO_WIDE[ACC_W-1:0];

   logic [W-1:0]              op_a;
   logic [W-1:0]              op_b;
   logic signed [2*W-1:0]     prod;
   logic signed [2*W-1:0]     term;
   logic signed [ACC_W-1:0]   term_ext;
   logic signed [ACC_W-1:0]   acc;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      op_a = BIAS;
      op_b = wb;
      for (int i = 0; i < N_INPUTS; i++) begin
         if (idx == IDX_W'(i)) begin
            op_a = x_flat[i*W +: W];
            op_b = w_flat[i*W +: W];
         end
      end
   end

   // Explicit sign extension keeps the multiply self-contained at 2W bits.
   assign prod     = $signed({{W{op_a[W-1]}}, op_a}) * $signed({{W{op_b[W-1]}}, op_b});
   // Arithmetic shift floors the product (toward minus infinity).
   assign term     = prod >>> Q_N;
   assign term_ext = {{(ACC_W-2*W){term[2*W-1]}}, term};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + term_ext;
      end
   end

   always_comb begin
      sat_sum = acc[W-1:0];
      if (acc > SAT_HI) begin
         sat_sum = SAT_HI[W-1:0];
      end else if (acc < SAT_LO) begin
         sat_sum = SAT_LO[W-1:0];
      end
   end

endmodule

// File: rtl/neuron_serial.sv
// neuron_serial: time-multiplexed perceptron. Captures N_INPUTS x/w pairs
// plus a bias weight, accumulates one product per cycle, saturates,
// activates (step or ReLU) and holds the result until consumed.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   x_in, w_in          : packed operands, element i at [i*W +: W]
//   wb                  : bias weight, multiplied by BIAS
//   out_valid/out_ready : result handshake
//   out                 : activated result, signed Q(Q_M).(Q_N)
module neuron_serial
   import neuron_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int SIGN     = 1,
   parameter int Q_M      = 15,
   parameter int Q_N      = 16,
   parameter logic [SIGN+Q_M+Q_N-1:0] BIAS = (SIGN+Q_M+Q_N)'(fx_one(Q_N)),
   parameter int ACT_MODE = ACT_RELU
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [N_INPUTS*(SIGN+Q_M+Q_N)-1:0]    x_in,
   input  logic [N_INPUTS*(SIGN+Q_M+Q_N)-1:0]    w_in,
   input  logic [SIGN+Q_M+Q_N-1:0]               wb,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [SIGN+Q_M+Q_N-1:0]               out
);

   localparam int W     = SIGN + Q_M + Q_N;
   localparam int IDX_W = $clog2(N_INPUTS + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS);
   localparam logic [63:0]      ONE_WIDE = fx_one(Q_N);
   localparam logic [W-1:0]     ONE      = ONE_WIDE[W-1:0];

   neuron_state_t           state;
   logic [IDX_W-1:0]        idx;
   logic [N_INPUTS*W-1:0]   x_reg;
   logic [N_INPUTS*W-1:0]   w_reg;
   logic [W-1:0]            wb_reg;
   logic [W-1:0]            sat_sum;
   logic [W-1:0]            act_value;
   logic                    acc_clear;
   logic                    acc_en;

   // Clear lands on the accept edge so the first MAC edge starts from zero.
   assign acc_clear = (state == IDLE) && in_valid;
   assign acc_en    = (state == MAC);

   neuron_mac_datapath #(
      .N_INPUTS (N_INPUTS),
      .W        (W),
      .Q_N      (Q_N),
      .BIAS     (BIAS),
      .IDX_W    (IDX_W)
   ) u_datapath (
      .clk     (clk),
      .rst     (rst),
      .clear   (acc_clear),
      .en      (acc_en),
      .idx     (idx),
      .x_flat  (x_reg),
      .w_flat  (w_reg),
      .wb      (wb_reg),
      .sat_sum (sat_sum)
   );

   always_comb begin
      act_value = '0;
      if (!sat_sum[W-1]) begin
         act_value = (ACT_MODE == ACT_STEP) ? ONE : sat_sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         // NOTE: operand registers are plain flops, not a RAM, so resetting
         // them is cheap and keeps simulation free of X after reset.
         x_reg     <= '0;
         w_reg     <= '0;
         wb_reg    <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg    <= x_in;
                  w_reg    <= w_in;
                  wb_reg   <= wb;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= MAC;
               end
            end
            MAC: begin
               idx <= idx + IDX_W'(1);
               if (idx == IDX_LAST) begin
                  state <= ACT;
               end
            end
            ACT: begin
               out       <= act_value;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_serial.sv
// tb_neuron_serial: directed self-checking bench. Two instances (ReLU and
// step) share stimulus; N_INPUTS=2, W=32, Q16.16, BIAS=1.0.
module tb_neuron_serial;

   localparam int N = 2;
   localparam int W = 32;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            out_ready;
   logic [N*W-1:0]  x_in;
   logic [N*W-1:0]  w_in;
   logic [W-1:0]    wb;
   logic            in_ready_r, in_ready_s;
   logic            out_valid_r, out_valid_s;
   logic [W-1:0]    out_r, out_s;

   int tests;
   int fails;
   int cycles;

   neuron_serial #(.N_INPUTS(N), .ACT_MODE(1)) dut_relu (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_r),
      .x_in      (x_in),
      .w_in      (w_in),
      .wb        (wb),
      .out_valid (out_valid_r),
      .out_ready (out_ready),
      .out       (out_r)
   );

   neuron_serial #(.N_INPUTS(N), .ACT_MODE(0)) dut_step (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_s),
      .x_in      (x_in),
      .w_in      (w_in),
      .wb        (wb),
      .out_valid (out_valid_s),
      .out_ready (out_ready),
      .out       (out_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] x0, x1, w0, w1, b);
      x_in = {x1, x0};
      w_in = {w1, w0};
      wb   = b;
   endtask

   // Accept one operand set, wait for the result, check latency and both
   // activations, then let out_ready (high) return the FSM to IDLE.
   task automatic run_txn(input string tag, input logic [31:0] x0, x1, w0, w1, b,
                          input logic [31:0] exp_r, exp_s);
      @(negedge clk);
      check({tag, " in_ready"}, {31'd0, in_ready_r}, 32'd1);
      drive(x0, x1, w0, w1, b);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cycles   = 0;
      while (!out_valid_r && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      check({tag, " latency"}, cycles, 32'd4);
      check({tag, " relu out"}, out_r, exp_r);
      check({tag, " step out"}, out_s, exp_s);
      check({tag, " step valid"}, {31'd0, out_valid_s}, 32'd1);
      @(negedge clk);
      check({tag, " valid drop"}, {31'd0, out_valid_r}, 32'd0);
      check({tag, " ready back"}, {31'd0, in_ready_r}, 32'd1);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

      // Reset state
      repeat (3) @(negedge clk);
      check("reset out", out_r, 32'h0);
      check("reset out_valid", {31'd0, out_valid_r}, 32'd0);
      check("reset in_ready", {31'd0, in_ready_r}, 32'd1);
      rst = 1'b0;

      // Basic weighted sum: 0.5 + 0.5 - 0.5 = 0.5
      run_txn("basic", 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000,
              32'hFFFF_8000, 32'h0000_8000, 32'h0001_0000);

      // Negative sum: -0.75 + 0 + 0.5 = -0.25
      run_txn("negative", 32'h0001_0000, 32'h0000_0000, 32'hFFFF_4000, 32'h0000_4CCD,
              32'h0000_8000, 32'h0000_0000, 32'h0000_0000);

      // Positive saturation: 60000.0 clamps to max
      run_txn("sat_pos", 32'h7530_0000, 32'h7530_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0000_0000, 32'h7FFF_FFFF, 32'h0001_0000);

      // Negative saturation: -60000.0 clamps to min, both activations give 0
      run_txn("sat_neg", 32'h7530_0000, 32'h7530_0000, 32'hFFFF_0000, 32'hFFFF_0000,
              32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

      // Truncation: -1 LSB * 0.5 floors to -1 LSB, negative so step gives 0
      run_txn("trunc", 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_8000, 32'h0000_0000,
              32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

      // Backpressure: hold the basic result for 5 cycles while in_valid pulses
      out_ready = 1'b0;
      @(negedge clk);
      drive(32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'hFFFF_8000);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cycles   = 0;
      while (!out_valid_r && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      check("bp latency", cycles, 32'd4);
      for (int k = 0; k < 5; k++) begin
         drive(32'h7530_0000, 32'h7530_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
         in_valid = (k % 2 == 0);
         @(negedge clk);
         check("bp hold relu", out_r, 32'h0000_8000);
         check("bp hold step", out_s, 32'h0001_0000);
         check("bp out_valid", {31'd0, out_valid_r}, 32'd1);
         check("bp in_ready", {31'd0, in_ready_r}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp release valid", {31'd0, out_valid_r}, 32'd0);
      check("bp release ready", {31'd0, in_ready_r}, 32'd1);
      run_txn("after_bp", 32'h7530_0000, 32'h7530_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0000_0000, 32'h7FFF_FFFF, 32'h0001_0000);

      // Reset mid-MAC, then a clean transaction
      @(negedge clk);
      drive(32'h7530_0000, 32'h7530_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid rst out", out_r, 32'h0);
      check("mid rst out_valid", {31'd0, out_valid_r}, 32'd0);
      check("mid rst in_ready", {31'd0, in_ready_r}, 32'd1);
      rst = 1'b0;
      run_txn("after_rst", 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000,
              32'hFFFF_8000, 32'h0000_8000, 32'h0001_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
